// File: rtl/float_to_fixed.sv
// IEEE-754 single -> {sign, 1.20 magnitude} fixed converter; F2X_ROUND_EN selects round-to-nearest-even.
// Latency: result valid sh+1 cycles after accept (4..24 normal, 1 special/saturate/zero).
// Backpressure: one operand in flight; in_ready low from accept until the result handshake.
module float_to_fixed #(
    parameter int FRAC_W = 20,
    parameter int FIX_W  = 1 + 1 + FRAC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FIX_W-1:0] out_data,
    output logic             ovf,
    output logic             unf,
    output logic             nv
);
    localparam int MAG_W = FIX_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [2:0] {C_NORM, C_ZERO, C_UNF, C_SAT, C_NAN} cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, in_cls;
    logic             sign_q;
    logic [23:0]      sig_q;
    logic [4:0]       cnt_q, in_cnt;
    logic [FIX_W-1:0] out_data_q, res_data;
    logic             ovf_q, unf_q, nv_q;
    logic             res_ovf, res_unf, res_nv;
    logic [7:0]       in_exp;
    logic [22:0]      in_man;
    logic             accept;
    logic [MAG_W-1:0] mag;
    logic             mag_ovf;

    assign in_exp = in_data[30:23];
    assign in_man = in_data[22:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        in_cls = C_NORM;
        if (in_exp == 8'hFF && in_man != 23'd0) begin
            in_cls = C_NAN;
        end else if (in_exp >= 8'd128) begin
            in_cls = C_SAT;
        end else if (in_exp == 8'd0) begin
            in_cls = C_ZERO;
        end else if (in_exp <= 8'd106) begin
            in_cls = C_UNF;
        end
        // 130-e fits in 3..23 for normal exponents, so the low 5 bits suffice
        in_cnt = (in_cls == C_NORM) ? (5'd2 - in_exp[4:0]) : 5'd0;
    end

`ifdef F2X_ROUND_EN
    logic             guard_q, sticky_q, round_up;
    logic [MAG_W:0]   mag_sum;

    always_comb begin
        round_up = guard_q & (sticky_q | sig_q[0]);
        mag_sum  = {1'b0, sig_q[MAG_W-1:0]} + {{MAG_W{1'b0}}, round_up};
    end

    assign mag     = mag_sum[MAG_W-1:0];
    assign mag_ovf = mag_sum[MAG_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (accept) begin
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (state_q == S_SHIFT && cnt_q != 5'd0) begin
            sticky_q <= sticky_q | guard_q;
            guard_q  <= sig_q[0];
        end
    end
`else
    assign mag     = sig_q[MAG_W-1:0];
    assign mag_ovf = 1'b0;
`endif

    always_comb begin
        res_data = '0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_nv   = 1'b0;
        case (cls_q)
            C_NORM: begin
                if (mag_ovf) begin
                    res_data = {sign_q, {MAG_W{1'b1}}};
                    res_ovf  = 1'b1;
                end else begin
                    res_data = {sign_q, mag};
                end
            end
            C_SAT: begin
                res_data = {sign_q, {MAG_W{1'b1}}};
                res_ovf  = 1'b1;
            end
            C_UNF:   res_unf = 1'b1;
            C_NAN:   res_nv  = 1'b1;
            default: res_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == 5'd0) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q     <= 1'b0;
            sig_q      <= '0;
            cnt_q      <= '0;
            cls_q      <= C_ZERO;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            nv_q       <= 1'b0;
        end else if (accept) begin
            sign_q <= in_data[31];
            sig_q  <= {1'b1, in_man};
            cnt_q  <= in_cnt;
            cls_q  <= in_cls;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            nv_q   <= 1'b0;
        end else if (state_q == S_SHIFT) begin
            if (cnt_q != 5'd0) begin
                sig_q <= {1'b0, sig_q[23:1]};
                cnt_q <= cnt_q - 5'd1;
            end else begin
                out_data_q <= res_data;
                ovf_q      <= res_ovf;
                unf_q      <= res_unf;
                nv_q       <= res_nv;
            end
        end
    end

    assign out_data = out_data_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign nv       = nv_q;

endmodule
